// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, buffers imem responses, hands {instr, pc} to decode; FETCH_PERF_CNT_EN adds perf counters.
// Latency: 2 cycles issue-to-dec_valid, 3 cycles redirect-to-dec_valid.
// Backpressure: issue stalls while buffered plus in-flight entries reach FIFO_DEPTH; redirect flushes everything.

module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic             head_vld,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push_vld && !clr;
  assign do_pop   = pop && head_vld;
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_nxt(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count == CNT_W'(DEPTH)));
endmodule

module instr_fetch_unit #(
  parameter int ADDR_W     = 5,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushes
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_ent_t;

  logic [ADDR_W-1:0] pc, rsp_pc;
  logic              rsp_valid;
  logic              issue, dec_hs;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  fetch_ent_t        push_ent, head_ent;

  assign imem_addr = pc;
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rsp_valid);
  assign issue     = !redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign dec_hs    = dec_valid && dec_ready;
  assign push_ent  = '{instr: imem_rdata, pc: rsp_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= ADDR_W'(RESET_PC);
      rsp_pc    <= '0;
      rsp_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= issue;
      if (issue) begin
        pc     <= pc + 1'b1;
        rsp_pc <= pc;
      end
    end
  end

  // A redirect clears the buffer and drops the response arriving this cycle.
  fetch_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (redirect_valid),
    .push_vld (rsp_valid),
    .push_dat (push_ent),
    .pop      (dec_hs),
    .head_vld (dec_valid),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  assign dec_instr = dec_valid ? head_ent.instr : '0;
  assign dec_pc    = dec_valid ? head_ent.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (dec_hs && perf_fetched != 16'hFFFF)         perf_fetched <= perf_fetched + 16'd1;
      if (redirect_valid && perf_flushes != 16'hFFFF) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; imem model returns 32'h1000_0000 + addr one cycle after the address.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [4:0]  dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_flushes;
`endif

  int checks = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 32'h1000_0000 + {27'd0, imem_addr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic v, input int pc);
    chk({tag, "_valid"}, 64'(dec_valid), 64'(v));
    chk({tag, "_pc"}, 64'(dec_pc), v ? 64'(pc % 32) : 64'd0);
    chk({tag, "_instr"}, 64'(dec_instr), v ? 64'(32'h1000_0000 + (pc % 32)) : 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 64'(dec_valid), 64'd0);
    chk({tag, "_rst_addr"}, 64'(imem_addr), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_rst_perf_f"}, 64'(perf_fetched), 64'd0);
    chk({tag, "_rst_perf_r"}, 64'(perf_flushes), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Test 1: reset state and free-running stream
    step();
    step();
    chk_dec("t1_in_reset", 1'b0, 0);
    chk("t1_in_reset_addr", 64'(imem_addr), 64'd0);
    rst_n = 1'b1;
    chk_dec("t1_c0", 1'b0, 0);
    step();
    chk_dec("t1_c1", 1'b0, 0);
    chk("t1_c1_addr", 64'(imem_addr), 64'd1);
    for (int k = 2; k <= 9; k++) begin
      step();
      chk_dec($sformatf("t1_c%0d", k), 1'b1, k - 2);
    end

    // Test 2/3: stall fills exactly 4 entries, release streams through the pc wrap
    dec_ready = 1'b0;
    reset_pulse("t2");
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_dec($sformatf("t2_stall%0d", k), (k >= 2), 0);
    end
    chk("t2_issue_stopped", 64'(imem_addr), 64'd4);
    step();
    chk("t2_still_stopped", 64'(imem_addr), 64'd4);
    dec_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      chk_dec($sformatf("t2_rel%0d", j), 1'b1, j);
      step();
    end

    // Test 4: redirect with 3 buffered entries and a response in flight
    dec_ready = 1'b0;
    reset_pulse("t4");
    for (int k = 1; k <= 4; k++) step();
    chk("t4_pre_addr", 64'(imem_addr), 64'd4);
    chk_dec("t4_pre", 1'b1, 0);
    redirect_valid = 1'b1;
    redirect_pc = 5'd20;
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    chk_dec("t4_r1", 1'b0, 0);
    chk("t4_r1_addr", 64'(imem_addr), 64'd20);
    step();
    chk_dec("t4_r2", 1'b0, 0);
    chk("t4_r2_addr", 64'(imem_addr), 64'd21);
    step();
    chk_dec("t4_r3", 1'b1, 20);
    step();
    chk_dec("t4_r4", 1'b1, 21);
    step();
    chk_dec("t4_r5", 1'b1, 22);

    // Test 5: redirect coinciding with a handshake, then back-to-back redirects
    dec_ready = 1'b1;
    reset_pulse("t5");
    step();
    step();
    chk_dec("t5_c2", 1'b1, 0);
    step();
    chk_dec("t5_c3", 1'b1, 1);
    step();
    chk_dec("t5_c4", 1'b1, 2);
    redirect_valid = 1'b1;
    redirect_pc = 5'd7;
    step();
    chk_dec("t5_c5", 1'b0, 0);
    chk("t5_c5_addr", 64'(imem_addr), 64'd7);
    redirect_pc = 5'd9;
    step();
    redirect_valid = 1'b0;
    chk_dec("t5_c6", 1'b0, 0);
    chk("t5_c6_addr", 64'(imem_addr), 64'd9);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_perf_fetched", 64'(perf_fetched), 64'd3);
    chk("t5_perf_flushes", 64'(perf_flushes), 64'd2);
`endif
    step();
    chk_dec("t5_c7", 1'b0, 0);
    step();
    chk_dec("t5_c8", 1'b1, 9);
    step();
    chk_dec("t5_c9", 1'b1, 10);

    // Test 6: reset mid-stream, restart, counters
    reset_pulse("t6");
    chk_dec("t6_c0", 1'b0, 0);
    step();
    step();
    chk_dec("t6_c2", 1'b1, 0);
    step();
    chk_dec("t6_c3", 1'b1, 1);
    step();
    chk_dec("t6_c4", 1'b1, 2);
    redirect_valid = 1'b1;
    redirect_pc = 5'd12;
    step();
    redirect_valid = 1'b0;
    chk_dec("t6_c5", 1'b0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_fetched", 64'(perf_fetched), 64'd3);
    chk("t6_perf_flushes", 64'(perf_flushes), 64'd1);
`endif
    step();
    step();
    chk_dec("t6_c7", 1'b1, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
